mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares a single-ported data memory between the CPU MEM stage and a DMA
// engine. The CPU normally wins; a starvation counter guarantees the DMA one
// forced grant after STARVE_MAX consecutive waiting cycles. Accesses with
// address bit 30 set are peripheral space: the CPU's go elsewhere (never
// stalled), the DMA's are rejected with dma_err.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   cpu_rd/wr/addr/wdata       CPU MEM-stage request
//   cpu_rdata, cpu_stall       CPU read data (combinational), stall request
//   dma_req/wr/addr/wdata      DMA request (dma_wr: 1=write, 0=read)
//   dma_ack, dma_err           accept / reject pulse, same cycle as request
//   dma_rdata, dma_rvalid      registered DMA read return, one cycle after ack
//   mem_rd/wr/addr/wdata       data memory command
//   mem_rdata                  data memory read data (same-cycle)
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        dma_err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int               CNT_W   = $clog2(STARVE_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_r;
    logic [31:0]      dma_rdata_r;
    logic             dma_rvalid_r;

    logic cpu_mem_s;    // CPU wants the data memory this cycle
    logic dma_ok_s;     // DMA request to memory space
    logic dma_bad_s;    // DMA request to peripheral space (rejected)
    logic force_dma_s;  // DMA has waited long enough to pre-empt the CPU
    logic gnt_dma_s;
    logic gnt_cpu_s;

    // Saturating increment; the counter never passes CNT_MAX.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v >= CNT_MAX) begin
            r = CNT_MAX;
        end else begin
            r = v + CNT_W'(1'b1);
        end
        return r;
    endfunction

    // Request qualification and grant decision; nothing is granted in reset.
    always_comb begin
        cpu_mem_s   = (cpu_rd | cpu_wr) & ~cpu_addr[30];
        dma_ok_s    = dma_req & ~dma_addr[30];
        dma_bad_s   = dma_req & dma_addr[30];
        force_dma_s = (starve_cnt_r == CNT_MAX);
        if (!reset) begin
            gnt_dma_s = 1'b0;
            gnt_cpu_s = 1'b0;
        end else if (force_dma_s && dma_ok_s) begin
            gnt_dma_s = 1'b1;
            gnt_cpu_s = 1'b0;
        end else if (cpu_mem_s) begin
            gnt_dma_s = 1'b0;
            gnt_cpu_s = 1'b1;
        end else if (dma_ok_s) begin
            gnt_dma_s = 1'b1;
            gnt_cpu_s = 1'b0;
        end else begin
            gnt_dma_s = 1'b0;
            gnt_cpu_s = 1'b0;
        end
    end

    // Memory command mux and same-cycle responses to both requesters.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 32'h0000_0000;
        mem_wdata = 32'h0000_0000;
        if (gnt_dma_s) begin
            mem_rd    = ~dma_wr;
            mem_wr    = dma_wr;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (gnt_cpu_s) begin
            // A simultaneous rd+wr from the CPU is treated as a write only.
            mem_rd    = cpu_rd & ~cpu_wr;
            mem_wr    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else begin
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
            mem_addr  = 32'h0000_0000;
            mem_wdata = 32'h0000_0000;
        end

        cpu_stall = gnt_dma_s & cpu_mem_s;
        if (gnt_cpu_s && cpu_rd && !cpu_wr) begin
            cpu_rdata = mem_rdata;
        end else begin
            cpu_rdata = 32'h0000_0000;
        end

        // Rejected DMA requests are still acknowledged so the engine moves on.
        dma_err = dma_bad_s & reset;
        dma_ack = gnt_dma_s | (dma_bad_s & reset);
    end

    // Starvation counter: counts only while a serviceable DMA request waits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_r <= '0;
        end else if (dma_ok_s && !gnt_dma_s) begin
            starve_cnt_r <= sat_inc(starve_cnt_r);
        end else begin
            starve_cnt_r <= '0;
        end
    end

    // DMA read return: capture data on a granted read, flag it for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dma_rdata_r  <= 32'h0000_0000;
            dma_rvalid_r <= 1'b0;
        end else if (gnt_dma_s && !dma_wr) begin
            dma_rdata_r  <= mem_rdata;
            dma_rvalid_r <= 1'b1;
        end else begin
            dma_rdata_r  <= dma_rdata_r;
            dma_rvalid_r <= 1'b0;
        end
    end

    assign dma_rdata  = dma_rdata_r;
    assign dma_rvalid = dma_rvalid_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Drives directed scenarios followed by randomized traffic. For every cycle the
// driver asks a reference model what the bus should look like and queues the
// expectation; a monitor on the falling edge pops and compares whenever the
// DUT or the expectation shows activity. A second instance with STARVE_MAX=0
// is checked for "DMA wins every contested cycle".
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int SM = 4;

    logic        clk;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        dma_req, dma_wr;
    logic [31:0] dma_addr, dma_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic        cpu_stall, dma_ack, dma_rvalid, dma_err, mem_rd, mem_wr;

    logic [31:0] z_cpu_rdata, z_dma_rdata, z_mem_addr, z_mem_wdata;
    logic        z_cpu_stall, z_dma_ack, z_dma_rvalid, z_dma_err, z_mem_rd, z_mem_wr;

    mem_bus_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_err(dma_err),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_bus_arbiter #(.STARVE_MAX(0)) dut0 (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(z_cpu_rdata), .cpu_stall(z_cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(z_dma_ack), .dma_rdata(z_dma_rdata), .dma_rvalid(z_dma_rvalid), .dma_err(z_dma_err),
        .mem_rd(z_mem_rd), .mem_wr(z_mem_wr), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic        rst;
        logic        c_rd;
        logic        c_wr;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic        d_req;
        logic        d_wr;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] mrd;
    } stim_t;

    typedef struct packed {
        int          cyc;
        logic        m_rd;
        logic        m_wr;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic        stall;
        logic [31:0] c_rdata;
        logic        ack;
        logic        err;
        logic        rvalid;
        logic [31:0] d_rdata;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model state, kept in plain terms.
    int          waited = 0;      // consecutive cycles the DMA has been refused
    bit          pend = 1'b0;     // a DMA read was accepted last cycle
    logic [31:0] held = 32'h0;    // last data returned to the DMA

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, expv);
        end
    endtask

    function automatic stim_t mk(input logic r, input logic crd, input logic cwr,
                                 input logic [31:0] ca, input logic [31:0] cw,
                                 input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [31:0] dwd,
                                 input logic [31:0] m);
        stim_t s;
        s.rst = r; s.c_rd = crd; s.c_wr = cwr; s.c_addr = ca; s.c_wdata = cw;
        s.d_req = dr; s.d_wr = dw; s.d_addr = da; s.d_wdata = dwd; s.mrd = m;
        return s;
    endfunction

    function automatic stim_t rand_stim(input bit heavy);
        stim_t s;
        s.rst     = 1'b1;
        s.c_rd    = heavy ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 5);
        s.c_wr    = ($urandom_range(0, 9) < 3);
        s.c_addr  = $urandom;
        s.c_addr[30] = heavy ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
        s.c_wdata = $urandom;
        s.d_req   = heavy ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 5);
        s.d_wr    = 1'($urandom_range(0, 1));
        s.d_addr  = $urandom;
        s.d_addr[30] = heavy ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
        s.d_wdata = $urandom;
        s.mrd     = $urandom;
        return s;
    endfunction

    // Drive one cycle of stimulus and queue what the bus should show.
    task automatic apply(input stim_t s, input bit force_rec);
        exp_t e;
        bit cpu_mem, dma_ok, dma_bad, dma_wins, cpu_wins;
        @(posedge clk);
        #1;
        reset = s.rst; cpu_rd = s.c_rd; cpu_wr = s.c_wr; cpu_addr = s.c_addr;
        cpu_wdata = s.c_wdata; dma_req = s.d_req; dma_wr = s.d_wr; dma_addr = s.d_addr;
        dma_wdata = s.d_wdata; mem_rdata = s.mrd;
        e = '0;
        e.cyc = cyc;
        if (!s.rst) begin
            waited = 0; pend = 1'b0; held = 32'h0;
            exp_q.push_back(e);
            return;
        end
        e.rvalid  = pend;
        e.d_rdata = held;
        cpu_mem  = (s.c_rd || s.c_wr) && !s.c_addr[30];
        dma_ok   = s.d_req && !s.d_addr[30];
        dma_bad  = s.d_req && s.d_addr[30];
        dma_wins = dma_ok && (waited >= SM || !cpu_mem);
        cpu_wins = cpu_mem && !dma_wins;
        if (dma_wins) begin
            e.m_rd = !s.d_wr; e.m_wr = s.d_wr; e.m_addr = s.d_addr; e.m_wdata = s.d_wdata;
            e.ack = 1'b1; e.stall = cpu_mem;
        end
        if (cpu_wins) begin
            e.m_wr = s.c_wr; e.m_rd = s.c_rd && !s.c_wr;
            e.m_addr = s.c_addr; e.m_wdata = s.c_wdata;
            e.c_rdata = (s.c_rd && !s.c_wr) ? s.mrd : 32'h0;
        end
        if (dma_bad) begin
            e.ack = 1'b1; e.err = 1'b1;
        end
        pend = dma_wins && !s.d_wr;
        if (pend) held = s.mrd;
        if (dma_ok && !dma_wins) waited = (waited + 1 > SM) ? SM : waited + 1;
        else waited = 0;
        if (force_rec || e.m_rd || e.m_wr || e.stall || e.ack || e.err || e.rvalid ||
            e.c_rdata != 32'h0 || e.m_addr != 32'h0 || e.m_wdata != 32'h0)
            exp_q.push_back(e);
    endtask

    // Monitor: compare whenever the DUT or the expectation shows activity.
    always @(negedge clk) begin : mon
        exp_t e;
        logic dact, eact, contested;
        dact = mem_rd | mem_wr | dma_ack | dma_err | dma_rvalid | cpu_stall |
               (cpu_rdata != 32'h0) | (mem_addr != 32'h0) | (mem_wdata != 32'h0);
        eact = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        if (dact || eact) begin
            if (eact) e = exp_q.pop_front();
            else e = '0;
            check("mem_rd", {31'h0, mem_rd}, {31'h0, e.m_rd});
            check("mem_wr", {31'h0, mem_wr}, {31'h0, e.m_wr});
            check("mem_addr", mem_addr, e.m_addr);
            check("mem_wdata", mem_wdata, e.m_wdata);
            check("cpu_stall", {31'h0, cpu_stall}, {31'h0, e.stall});
            check("cpu_rdata", cpu_rdata, e.c_rdata);
            check("dma_ack", {31'h0, dma_ack}, {31'h0, e.ack});
            check("dma_err", {31'h0, dma_err}, {31'h0, e.err});
            check("dma_rvalid", {31'h0, dma_rvalid}, {31'h0, e.rvalid});
            if (eact) check("dma_rdata", dma_rdata, e.d_rdata);
        end
        // With no starvation budget the DMA takes every contested cycle.
        contested = reset && (cpu_rd || cpu_wr) && !cpu_addr[30] && dma_req && !dma_addr[30];
        if (contested || (z_cpu_stall === 1'b1)) begin
            check("sm0_stall", {31'h0, z_cpu_stall}, {31'h0, contested});
            if (contested) check("sm0_addr", z_mem_addr, dma_addr);
        end
    end

    initial begin
        stim_t idle;
        reset = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_wr = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0; mem_rdata = 32'h0;
        idle = mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

        repeat (3) apply(mk(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h77), 1'b1);

        // CPU-only read
        apply(mk(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF), 1'b1);
        apply(idle, 1'b1);
        // DMA-only read, data returned next cycle
        apply(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h1234_5678), 1'b1);
        apply(idle, 1'b1);
        // Continuous contention: CPU x4, forced DMA, CPU again...
        for (int i = 0; i < 12; i++)
            apply(mk(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0,
                     32'hA000_0000 + 32'(i)), 1'b1);
        apply(idle, 1'b1);
        // Peripheral CPU store alongside a DMA write
        apply(mk(1'b1, 1'b0, 1'b1, 32'h4000_000C, 32'h1111_1111, 1'b1, 1'b1, 32'h30,
                 32'h2222_2222, 32'h0), 1'b1);
        // DMA to peripheral space is rejected
        apply(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 32'h5555), 1'b1);
        // CPU rd+wr together: write only
        apply(mk(1'b1, 1'b1, 1'b1, 32'h48, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0, 32'h0, 32'h9999), 1'b1);
        // DMA read ack, then reset in the following cycle
        apply(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 32'h6666_7777), 1'b1);
        apply(mk(1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 32'h0), 1'b1);
        apply(mk(1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 32'h0), 1'b1);
        for (int i = 0; i < 7; i++)
            apply(mk(1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b1, 32'h60, 32'h0BAD_0000,
                     32'hB000_0000 + 32'(i)), 1'b1);

        // Randomized traffic in segments of light and heavy contention
        for (int i = 0; i < 600; i++) begin
            if (i == 300)
                apply(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0), 1'b1);
            else
                apply(rand_stim(((i / 20) % 2) == 1), 1'b0);
        end
        repeat (3) apply(idle, 1'b0);

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
